// File: rtl/baby_kyber_pkg.sv
// Shared constants, state encoding and modular helpers for the Baby Kyber decrypt core.
package baby_kyber_pkg;

  localparam int Q  = 17;
  localparam int N  = 4;
  localparam int K  = 2;
  localparam int W  = 32;
  localparam int CW = 5;               // canonical coefficient width
  localparam int PW = 9;               // product width, (Q-1)^2 = 256
  localparam int TW = 3;               // i+j reaches 2N-2
  localparam int KB = (K > 1) ? $clog2(K) : 1;
  localparam int NB = (N > 1) ? $clog2(N) : 1;

  localparam logic signed [W-1:0] QS = Q;

  typedef enum logic [1:0] {IDLE, MAC, DONE} dec_state_e;

  // SV % truncates toward zero, so a negative remainder needs one fold-up.
  function automatic logic [CW-1:0] mod_q(input logic signed [W-1:0] x);
    logic signed [W-1:0] r;
    r = x % QS;
    if (r < 0) r = r + QS;
    return r[CW-1:0];
  endfunction

  // round(2d/Q) mod 2 for Q=17 collapses to a window test.
  function automatic logic decode_bit(input logic [CW-1:0] d);
    return (d >= CW'(5)) && (d <= CW'(12));
  endfunction

endpackage

// File: rtl/baby_kyber_decrypt_mac.sv
// Negacyclic accumulator bank: one signed-wrap product update per cycle, kept canonical.
module negacyclic_mac
  import baby_kyber_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            en,
  input  logic [N*CW-1:0] load_value,
  input  logic [PW-1:0]   p,
  input  logic [TW-1:0]   t,
  output logic [N*CW-1:0] acc_nxt
);

  localparam logic [9:0] QW   = 10'(Q);
  localparam logic [9:0] BIAS = 10'(16 * Q);  // multiple of Q above any product

  logic [N-1:0][CW-1:0] bank, bank_nxt;

  for (genvar n = 0; n < N; n++) begin : g_lane
    logic [CW-1:0] sub, add, nxt;

    assign sub = CW'((10'(bank[n]) + BIAS - 10'(p)) % QW);
    assign add = CW'((10'(bank[n]) + 10'(p)) % QW);

    // t<N subtracts into acc[t]; t>=N wraps with x^N = -1 and adds into acc[t-N].
    always_comb begin
      nxt = bank[n];
      if (load)
        nxt = load_value[n*CW +: CW];
      else if (en) begin
        if (t == TW'(n))          nxt = sub;
        else if (t == TW'(n + N)) nxt = add;
      end
    end

    assign bank_nxt[n] = nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) bank <= '0;
    else     bank <= bank_nxt;
  end

  assign acc_nxt = bank_nxt;

endmodule

// File: rtl/baby_kyber_decrypt.sv
// Baby Kyber decrypt: d = v - s^T u in Z_Q[x]/(x^N+1), one product per cycle, then 1-bit decode.
module baby_kyber_decrypt
  import baby_kyber_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K*N*W-1:0]  u,
  input  logic [N*W-1:0]    v,
  input  logic [K*N*W-1:0]  s,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*CW-1:0]   coef,
  output logic [N-1:0]      msg
);

  dec_state_e state, nxt_state;

  logic [K*N-1:0][CW-1:0] u_red, s_red, su, ss;
  logic [N*CW-1:0]        v_red, acc_nxt;
  logic [N-1:0]           msg_nxt;
  logic [KB-1:0]          k;
  logic [NB-1:0]          i, j;
  logic [PW-1:0]          p;
  logic [TW-1:0]          t;
  logic                   load, en, last;

  for (genvar e = 0; e < K*N; e++) begin : g_red
    assign u_red[e] = mod_q(u[e*W +: W]);
    assign s_red[e] = mod_q(s[e*W +: W]);
  end

  for (genvar n = 0; n < N; n++) begin : g_v
    assign v_red[n*CW +: CW] = mod_q(v[n*W +: W]);
    assign msg_nxt[n]        = decode_bit(acc_nxt[n*CW +: CW]);
  end

  assign p    = {{(PW-CW){1'b0}}, ss[{k, i}]} * {{(PW-CW){1'b0}}, su[{k, j}]};
  assign t    = TW'(i) + TW'(j);
  assign last = (k == KB'(K-1)) && (i == NB'(N-1)) && (j == NB'(N-1));

  negacyclic_mac u_mac (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .en         (en),
    .load_value (v_red),
    .p          (p),
    .t          (t),
    .acc_nxt    (acc_nxt)
  );

  always_comb begin
    nxt_state = state;
    in_ready  = 1'b0;
    load      = 1'b0;
    en        = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) begin
          load      = 1'b1;
          nxt_state = MAC;
        end
      end
      MAC: begin
        en = 1'b1;
        if (last) nxt_state = DONE;
      end
      DONE:    if (out_ready) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      i     <= '0;
      j     <= '0;
      su    <= '0;
      ss    <= '0;
      coef  <= '0;
      msg   <= '0;
    end else begin
      state <= nxt_state;
      if (load) begin
        su <= u_red;
        ss <= s_red;
        k  <= '0;
        i  <= '0;
        j  <= '0;
      end
      // j fastest, then i, then k
      if (en) begin
        j <= j + NB'(1);
        if (j == NB'(N-1)) begin
          i <= i + NB'(1);
          if (i == NB'(N-1)) k <= k + KB'(1);
        end
        if (last) begin
          coef <= acc_nxt;
          msg  <= msg_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_baby_kyber_decrypt.sv
// Scoreboard bench for baby_kyber_decrypt: directed cases, back-pressure, abort, random vectors.
module tb_baby_kyber_decrypt;
  import baby_kyber_pkg::*;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [K*N*W-1:0] u = '0, s = '0;
  logic [N*W-1:0]   v = '0;
  logic [N*CW-1:0]  coef;
  logic [N-1:0]     msg;

  int n_cmp = 0, n_bad = 0;
  int ua[K][N], sa[K][N], va[N];

  typedef struct packed {
    logic [N*CW-1:0] coef;
    logic [N-1:0]    msg;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  baby_kyber_decrypt dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .u(u), .v(v), .s(s), .out_valid(out_valid), .out_ready(out_ready),
    .coef(coef), .msg(msg)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int mq(int x);
    int r = x % Q;
    return (r < 0) ? r + Q : r;
  endfunction

  // Golden: full-precision polynomial product, reduced once at the end.
  function automatic exp_t model();
    int d[N];
    exp_t e;
    for (int n = 0; n < N; n++) d[n] = mq(va[n]);
    for (int kk = 0; kk < K; kk++)
      for (int ii = 0; ii < N; ii++)
        for (int jj = 0; jj < N; jj++) begin
          int pr = mq(sa[kk][ii]) * mq(ua[kk][jj]);
          if (ii + jj < N) d[ii+jj]   -= pr;
          else             d[ii+jj-N] += pr;
        end
    for (int n = 0; n < N; n++) begin
      d[n] = mq(d[n]);
      e.coef[n*CW +: CW] = CW'(d[n]);
      e.msg[n] = 1'(((4 * d[n] + Q) / (2 * Q)) % 2);
    end
    return e;
  endfunction

  task automatic clear_ops();
    for (int kk = 0; kk < K; kk++)
      for (int n = 0; n < N; n++) begin ua[kk][n] = 0; sa[kk][n] = 0; end
    for (int n = 0; n < N; n++) va[n] = 0;
  endtask

  task automatic rand_ops();
    for (int kk = 0; kk < K; kk++)
      for (int n = 0; n < N; n++) begin ua[kk][n] = $urandom(); sa[kk][n] = $urandom(); end
    for (int n = 0; n < N; n++) va[n] = $urandom();
  endtask

  task automatic drive_ops();
    for (int kk = 0; kk < K; kk++)
      for (int n = 0; n < N; n++) begin
        u[(kk*N+n)*W +: W] = ua[kk][n];
        s[(kk*N+n)*W +: W] = sa[kk][n];
      end
    for (int n = 0; n < N; n++) v[n*W +: W] = va[n];
  endtask

  task automatic scramble();
    for (int e = 0; e < K*N; e++) begin u[e*W +: W] = $urandom(); s[e*W +: W] = $urandom(); end
    for (int n = 0; n < N; n++) v[n*W +: W] = $urandom();
  endtask

  task automatic wait_ready();
    int c = 0;
    while (!in_ready && c < 50) begin step(); c++; end
    chk("ready_wait", in_ready, 1);
  endtask

  task automatic run_op(input int stall, input bit given, input exp_t gexp);
    exp_t e;
    wait_ready();
    drive_ops();
    in_valid = 1'b1;
    sb.push_back(given ? gexp : model());
    step();
    in_valid = 1'b0;
    scramble();
    repeat (31) step();
    chk("lat_early", out_valid, 0);
    step();
    chk("lat_valid", out_valid, 1);
    e = model();
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = sb.pop_front();
      chk("coef", coef, e.coef);
      chk("msg", msg, e.msg);
    end
    for (int c = 0; c < stall; c++) begin
      in_valid = (c == 2);
      step();
      chk("hold_coef", coef, e.coef);
      chk("hold_msg", msg, e.msg);
      chk("hold_ready", in_ready, 0);
      chk("hold_valid", out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("ready_after", in_ready, 1);
    chk("valid_after", out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    exp_t g;
    g = '0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_coef", coef, 0);
    chk("rst_msg", msg, 0);
    rst = 1'b0;
    step();
    chk("ready_post_rst", in_ready, 1);

    // zero key
    clear_ops();
    va = '{0, 9, 4, 16};
    g.coef = {5'd16, 5'd4, 5'd9, 5'd0};
    g.msg  = 4'b0010;
    run_op(0, 1'b1, g);

    // x^3 * x = -1 wraps into d0
    clear_ops();
    sa[0][3] = 1;
    ua[0][1] = 1;
    va[0]    = 8;
    g.coef = {5'd0, 5'd0, 5'd0, 5'd9};
    g.msg  = 4'b0001;
    run_op(1, 1'b1, g);

    // negative v, with long back-pressure
    clear_ops();
    va = '{0, 0, -8, -1};
    g.coef = {5'd16, 5'd9, 5'd0, 5'd0};
    g.msg  = 4'b0100;
    run_op(10, 1'b1, g);

    // abort mid-MAC
    rand_ops();
    wait_ready();
    drive_ops();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    chk("abort_valid", out_valid, 0);
    chk("abort_coef", coef, 0);
    chk("abort_msg", msg, 0);
    chk("abort_ready", in_ready, 0);
    rst = 1'b0;
    step();
    chk("abort_ready_after", in_ready, 1);
    rand_ops();
    run_op(0, 1'b0, g);

    for (int r = 0; r < 1000; r++) begin
      rand_ops();
      run_op(int'($urandom_range(0, 4)), 1'b0, g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/baby_kyber_decrypt.md
# baby_kyber_decrypt

Decryption-side core for the Baby Kyber datapath. It accepts a ciphertext (vector `u` of K polynomials plus polynomial `v`) and secret key `s`. It computes `d = v − sᵀ·u` in Z_Q[x]/(x^N+1) sequentially, one coefficient product per cycle, then decodes each coefficient of `d` into one message bit. It sits opposite the encryption-side polynomial multiplier. Inputs and outputs use valid/ready handshakes.

## Interface
- `Q`, 17, coefficient modulus
- `N`, 4, coefficients per polynomial (ring x^N+1)
- `K`, 2, module rank (polynomials per vector)
- `W`, 32, signed input coefficient width

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  ciphertext/key present
- `in_ready`  out  1  block idle, can accept
- `u`  in  K×N×W signed  ciphertext vector u[k][n]
- `v`  in  N×W signed  ciphertext polynomial v[n]
- `s`  in  K×N×W signed  secret key s[k][n]
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer accepts result
- `coef`  out  N×5  unsigned canonical d[n] in 0..Q−1
- `msg`  out  N  decoded bits, msg[n] from d[n]

## Operation
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: capture u, s, v, each reduced to canonical 0..Q−1 (negative x → ((x mod Q)+Q) mod Q).
  - Initialise acc[n]=v[n] and indices k=i=j=0, then go to MAC.
- MAC: one step per cycle, iterating j fastest, then i, then k; K·N·N = 32 steps.
  - p = s[k][i]·u[k][j] (≤ 256, 9 bits), t = i+j.
  - If t<N: acc[t] = (acc[t] − p) mod Q.
  - Else: acc[t−N] = (acc[t−N] + p) mod Q (negacyclic wrap).
  - Each acc is kept canonical after every step; no wide accumulation.
- On the final step (k=K−1, i=j=N−1):
  - Register coef = final acc.
  - Register msg[n] = 1 iff 5 ≤ d[n] ≤ 12, i.e. round(2d/Q) mod 2 for Q=17.
  - Set out_valid, go to DONE.
- DONE:
  - `out_valid`=1; `coef`/`msg` held stable.
  - `in_ready`=0; `in_valid` is ignored.
  - On `out_ready`: clear out_valid and go to IDLE.
- Unused inputs (u, s, v outside acceptance) have no effect. Captured operands are internal, so the source may change them after the handshake.

## Timing
- Reset:
  - State IDLE; out_valid=0, coef=0, msg=0, counters=0.
  - `in_ready`=0 while `rst` is high, and 1 from the first cycle after deassertion.
- Latency:
  - Acceptance at edge E0; MAC steps at edges E1..E32.
  - out_valid is high after E32, i.e. 32 cycles after the accepting cycle.
- Throughput: one operation per 32 cycles plus the DONE handshake. No overlap. in_ready returns to 1 in the cycle after the output handshake.
- Back-pressure: DONE persists indefinitely with outputs frozen.
- Reset mid-MAC or mid-DONE: aborts the operation. The next cycle shows reset values and no partial result is ever presented.
- `rst` has priority over any handshake in the same cycle.

## Structure
- Package `baby_kyber_pkg`:
  - Constants Q, N, K, coefficient width (5).
  - State enum `dec_state_e`.
  - Functions `mod_q` (signed-safe canonical reduction) and `decode_bit`.
- Sub-module `negacyclic_mac`:
  - Holds the N-entry accumulator bank.
  - Takes (p, t, load, load_value) and performs the signed-wrap update plus reduction.
- The top level holds the FSM, index counters, operand registers and output registers.

## Test plan
- **Zero key:** s=0, v=[0,9,4,16] → after 32 cycles coef=[0,9,4,16], msg=4'b0010.
- **Wrap:** s[0]=[0,0,0,1], u[0]=[0,1,0,0], s[1]=u[1]=0, v=[8,0,0,0]. Since x³·x = −1, d0 = 8+1 = 9 → coef=[9,0,0,0], msg=4'b0001.
- **Negative inputs:** s=0, v=[0,0,−8,−1] → coef=[0,0,9,16], msg=4'b0100.
- **Back-pressure:** out_ready=0 for 10 cycles after out_valid.
  - coef/msg stable, in_ready=0, and a second in_valid pulse is ignored.
  - Raising out_ready gives in_ready=1 next cycle.
- **Reset mid-MAC:** assert rst 10 cycles after acceptance.
  - Next cycle: out_valid=0, coef=0, msg=0.
  - A fresh operation afterwards produces correct results.
- **Random:** 1000 vectors (full W-bit signed range) vs. golden model of v − sᵀu mod Q. Check exact 32-cycle latency and random out_ready stalls.
